// File: rtl/regbank_demux_wr.sv
// regbank_demux_wr
//   Write side of a DEPTH x WIDTH register bank. The whole bank is exposed as
//   one packed, fully registered vector for a downstream sel-indexed read mux.
//   Single-word writes use a valid/ready handshake. A bulk-clear sequencer
//   zeroes one entry per cycle. Entry 0 can be hardwired to zero.
//
// Ports
//   clk_i        single clock, all state updates on the rising edge
//   rst_i        synchronous, active-high reset
//   wr_valid_i   write request valid
//   wr_ready_o   write can be accepted this cycle (combinational)
//   wr_addr_i    target entry index
//   wr_data_i    write data
//   wr_ack_o     one-cycle pulse the cycle after an accepted write
//   clr_i        start bulk clear (level, sampled in IDLE)
//   busy_o       bulk clear in progress
//   clr_done_o   one-cycle pulse when a bulk clear completes
//   bank_o       packed bank, entry k at [k*WIDTH +: WIDTH]
module regbank_demux_wr #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic                     wr_ack_o,
    input  logic                     clr_i,
    output logic                     busy_o,
    output logic                     clr_done_o,
    output logic [DEPTH*WIDTH-1:0]   bank_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                 state;
    logic [AW-1:0]          cnt;
    logic [DEPTH*WIDTH-1:0] bank_q;
    logic                   wr_fire;
    logic                   wr_store;

    // A pending clear (or one in progress) blocks writes, which gives clr_i
    // priority over a same-cycle write; the requester keeps valid asserted.
    assign wr_ready_o = ~rst_i & (state == IDLE) & ~clr_i;
    assign wr_fire    = wr_valid_i & wr_ready_o;

    // With ZERO_REG, a write to entry 0 is still handshaken and acked, but the
    // data is dropped. Reset and clear are the only other writers of entry 0,
    // and both write zero, so it never leaves zero.
    assign wr_store   = wr_fire & ~(ZERO_REG & (wr_addr_i == '0));

    assign busy_o = (state == CLEAR);
    assign bank_o = bank_q;

    // NOTE: the bank is reset as a whole on purpose: the read side expects a
    // defined all-zero bank after reset, so these are plain flops, not a RAM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every flop samples the pre-edge values regardless of order.
            state      <= IDLE;
            cnt        <= '0;
            bank_q     <= '0;
            wr_ack_o   <= 1'b0;
            clr_done_o <= 1'b0;
        end else begin
            wr_ack_o   <= wr_fire;
            clr_done_o <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (clr_i) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end else if (wr_store) begin
                        bank_q[int'(wr_addr_i)*WIDTH +: WIDTH] <= wr_data_i;
                    end
                end

                CLEAR: begin
                    bank_q[int'(cnt)*WIDTH +: WIDTH] <= '0;
                    // cnt wraps to 0 naturally because DEPTH is a power of two.
                    cnt <= cnt + 1'b1;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state      <= IDLE;
                        clr_done_o <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regbank_demux_wr.sv
module tb_regbank_demux_wr;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = DEPTH * WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          clr;

    // Instance with entry 0 hardwired to zero
    logic          ready1, ack1, busy1, done1;
    logic [BW-1:0] bank1;
    // Instance with entry 0 as an ordinary entry, same stimulus
    logic          ready0, ack0, busy0, done0;
    logic [BW-1:0] bank0;

    regbank_demux_wr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(ready1),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ack_o(ack1),
        .clr_i(clr), .busy_o(busy1), .clr_done_o(done1), .bank_o(bank1)
    );

    regbank_demux_wr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1'b0)) dut_nz (
        .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(ready0),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_ack_o(ack0),
        .clr_i(clr), .busy_o(busy0), .clr_done_o(done0), .bank_o(bank0)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: word arrays plus "entries still to clear"
    logic [31:0] m1 [DEPTH];
    logic [31:0] m0 [DEPTH];
    int          clr_left = 0;
    logic        exp_ack  = 1'b0;
    logic        exp_done = 1'b0;
    logic        last_ready;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] pack(input logic [31:0] m [DEPTH]);
        logic [BW-1:0] v;
        for (int k = 0; k < DEPTH; k++) v[k*WIDTH +: WIDTH] = m[k];
        return v;
    endfunction

    function automatic logic [31:0] entry(input logic [BW-1:0] v, input int k);
        return v[k*WIDTH +: WIDTH];
    endfunction

    // Apply one rising edge to the model, given the inputs present before it
    task automatic model_step(input logic ready);
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin m1[k] = '0; m0[k] = '0; end
            clr_left = 0;
            exp_ack  = 1'b0;
            exp_done = 1'b0;
        end else begin
            exp_ack  = wr_valid && ready;
            exp_done = 1'b0;
            if (clr_left > 0) begin
                m1[DEPTH - clr_left] = '0;
                m0[DEPTH - clr_left] = '0;
                clr_left--;
                exp_done = (clr_left == 0);
            end else if (clr) begin
                clr_left = DEPTH;
            end else if (wr_valid) begin
                if (wr_addr != 0) m1[wr_addr] = wr_data;
                m0[wr_addr] = wr_data;
            end
        end
    endtask

    // One clock cycle: check ready before the edge, step the model, then
    // check every registered output shortly after the edge.
    task automatic cycle();
        logic exp_ready;
        #1;
        exp_ready  = !rst && (clr_left == 0) && !clr;
        last_ready = ready1;
        check("wr_ready", BW'(ready1), BW'(exp_ready));
        check("wr_ready_nz", BW'(ready0), BW'(exp_ready));
        @(posedge clk);
        model_step(exp_ready);
        #1;
        check("wr_ack", BW'(ack1), BW'(exp_ack));
        check("wr_ack_nz", BW'(ack0), BW'(exp_ack));
        check("clr_done", BW'(done1), BW'(exp_done));
        check("clr_done_nz", BW'(done0), BW'(exp_done));
        check("busy", BW'(busy1), BW'(clr_left > 0));
        check("busy_nz", BW'(busy0), BW'(clr_left > 0));
        check("bank", bank1, pack(m1));
        check("bank_nz", bank0, pack(m0));
    endtask

    task automatic idle_inputs();
        rst = 1'b0; clr = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    endtask

    task automatic write(input int a, input logic [31:0] d);
        wr_valid = 1'b1; wr_addr = AW'(a); wr_data = d;
        cycle();
        wr_valid = 1'b0;
    endtask

    int  busy_cnt, done_cnt, nready_cnt, n;
    bit  seen;

    initial begin
        for (int k = 0; k < DEPTH; k++) begin m1[k] = 'x; m0[k] = 'x; end
        idle_inputs();

        // Initial reset
        rst = 1'b1;
        cycle();
        rst = 1'b0;

        // Preload, then reset: bank must return to zero with no pulses
        wr_valid = 1'b1;
        for (int k = 1; k < 6; k++) begin
            wr_addr = AW'(k); wr_data = 32'hA000_0000 + 32'(k);
            cycle();
        end
        wr_valid = 1'b0;
        rst = 1'b1;
        cycle();
        check("reset_bank_zero", bank1, '0);
        check("reset_ack_low", BW'(ack1), '0);
        rst = 1'b0;
        cycle();
        check("ready_after_reset", BW'(last_ready), BW'(1));

        // Back-to-back writes, same address twice
        wr_valid = 1'b1;
        wr_addr = 5'd5;  wr_data = 32'hDEADBEEF; cycle();
        check("ack_w1", BW'(ack1), BW'(1));
        wr_addr = 5'd31; wr_data = 32'h12345678; cycle();
        check("ack_w2", BW'(ack1), BW'(1));
        wr_addr = 5'd5;  wr_data = 32'h000000A5; cycle();
        check("ack_w3", BW'(ack1), BW'(1));
        wr_valid = 1'b0;
        cycle();
        check("entry5", BW'(entry(bank1, 5)), BW'(32'h000000A5));
        check("entry31", BW'(entry(bank1, 31)), BW'(32'h12345678));
        check("entry4", BW'(entry(bank1, 4)), '0);

        // Entry 0 behaviour on both instances
        write(0, 32'hFFFFFFFF);
        check("zero_reg_ack", BW'(ack1), BW'(1));
        check("zero_reg_entry0", BW'(entry(bank1, 0)), '0);
        check("nz_entry0", BW'(entry(bank0, 0)), BW'(32'hFFFFFFFF));

        // Fill with own index, then a single clr pulse
        for (int k = 0; k < DEPTH; k++) write(k, 32'(k));
        busy_cnt = 0; done_cnt = 0; nready_cnt = 0;
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        if (busy1) busy_cnt++;
        for (int j = 1; j <= DEPTH; j++) begin
            cycle();
            if (!last_ready) nready_cnt++;
            if (busy1) busy_cnt++;
            if (done1) done_cnt++;
            check("clr_entry_zeroed", BW'(entry(bank0, j - 1)), '0);
            if (j < DEPTH) check("clr_entry_kept", BW'(entry(bank0, j)), BW'(j));
        end
        for (int j = 0; j < 3; j++) begin
            cycle();
            if (done1) done_cnt++;
        end
        check("clr_busy_cycles", BW'(busy_cnt), BW'(DEPTH));
        check("clr_done_once", BW'(done_cnt), BW'(1));
        check("clr_ready_low", BW'(nready_cnt), BW'(DEPTH));

        // clr_i and a write in the same cycle; valid held until accepted
        clr = 1'b1; wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'h55;
        seen = 1'b0;
        n = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            cycle();
            if (i == 1) begin
                check("clr_wr_not_ready", BW'(last_ready), '0);
                clr = 1'b0;
            end
            if (ack1) begin seen = 1'b1; n = i; end
        end
        wr_valid = 1'b0;
        check("held_write_latency", BW'(n), BW'(DEPTH + 2));
        check("held_write_entry3", BW'(entry(bank1, 3)), BW'(32'h55));

        // Reset during clear cycle 10
        for (int k = 1; k < 8; k++) write(k, 32'hC0DE_0000 + 32'(k));
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        for (int j = 0; j < 9; j++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_bank_zero", bank0, '0);
        check("abort_idle", BW'(busy1), '0);
        done_cnt = 0;
        for (int j = 0; j < DEPTH + 4; j++) begin
            cycle();
            if (done1) done_cnt++;
        end
        check("abort_no_done", BW'(done_cnt), '0);
        write(9, 32'h0BADF00D);
        cycle();
        check("abort_write_after", BW'(entry(bank1, 9)), BW'(32'h0BADF00D));

        // Randomized traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rst      = ($urandom_range(199) == 0);
            clr      = ($urandom_range(39) == 0);
            wr_valid = $urandom_range(1);
            wr_addr  = AW'($urandom);
            wr_data  = $urandom;
            cycle();
        end
        idle_inputs();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
